rd_ptr_handler: RTL and testbench
=================================

// Module: rd_ptr_handler
// PURPOSE
//  Read-side pointer logic of the asynchronous FIFO, the rclk-domain counterpart of the write-pointer handler.
//  - Synchronises the write handler's gray_wptr into rclk and maintains the binary/gray read pointer.
//  - Generates empty, almost_empty, occupancy and a sticky underflow flag.
//  - gray_rptr is returned to the write domain for the full check.
// PARAMETERS
//  PTR_WIDTH    4  pointer width = address bits + 1 (wrap bit); FIFO depth = 2**(PTR_WIDTH-1)
//  SYNC_STAGES  2  flops in the gray_wptr synchroniser; legal range 2..3
//  AE_THRESH    1  almost_empty asserts when rd_count <= AE_THRESH
// PORTS
//  rclk           in   1            read clock
//  rrst_n         in   1            async active-low reset; release is synchronous to rclk, handled externally
//  r_en           in   1            read request
//  clr_underflow  in   1            one-cycle pulse; clears underflow
//  gray_wptr      in   PTR_WIDTH    write pointer in gray code, from the wclk domain; unsynchronised
//  binary_rptr    out  PTR_WIDTH    read pointer, binary; low PTR_WIDTH-1 bits drive the memory read address
//  gray_rptr      out  PTR_WIDTH    read pointer, gray code, registered; goes to the write-domain synchroniser
//  empty          out  1            FIFO empty, registered
//  almost_empty   out  1            rd_count <= AE_THRESH, registered
//  rd_count       out  PTR_WIDTH    occupancy as seen from rclk, registered; 0..depth
//  underflow      out  1            sticky; set by a read attempted while empty
// BEHAVIOUR
//  Reset (async, rrst_n=0):
//   - All flops clear immediately, including synchroniser flops.
//   - binary_rptr=0, gray_rptr=0, rd_count=0, underflow=0; empty=1, almost_empty=1.
//   - Reset mid-burst abandons the read in flight; no partial update survives.
//  Synchroniser:
//   - gray_wptr passes through SYNC_STAGES rclk flops, giving wptr_s.
//   - wptr_bin = gray2bin(wptr_s), combinational.
//  Read accept:
//   - rd_ok = r_en & ~empty.
//   - On rd_ok: binary_rptr <= binary_rptr+1, modulo 2**PTR_WIDTH; otherwise it holds.
//   - rptr_next = binary_rptr + rd_ok.
//   - gray_rptr <= rptr_next ^ (rptr_next>>1). Exactly one bit changes per read, including at wrap.
//  empty:
//   - empty <= (bin2gray(rptr_next) == wptr_s).
//   - Empty asserts on the same edge that consumes the last word.
//  rd_count:
//   - rd_count <= wptr_bin - rptr_next, PTR_WIDTH-bit modulo subtraction.
//   - The value is conservative: a write becomes visible after SYNC_STAGES+1 rclk edges.
//   - It never exceeds depth.
//  almost_empty:
//   - almost_empty <= (wptr_bin - rptr_next) <= AE_THRESH.
//   - It is consistent with rd_count on every cycle.
//  underflow:
//   - Set on any edge with r_en & empty; the pointer does not move.
//   - Cleared by clr_underflow.
//   - Simultaneous set and clear: set wins.
//  Latency:
//   - A gray_wptr change is reflected in empty, rd_count and almost_empty SYNC_STAGES+1 rclk edges later.
//   - A read is reflected in all outputs 1 edge later.
//  Simultaneous events:
//   - Read and newly synchronised write on the same edge: both are applied through rptr_next and wptr_bin.
//   - No cycle ever shows a spurious empty or a count outside 0..depth.
// STRUCTURE
//  Shared package fifo_pkg:
//   - PTR_WIDTH default.
//   - Functions bin2gray() and gray2bin().
//   - The write-pointer handler and this block share it.
//  Sub-module ptr_sync:
//   - Parameterised SYNC_STAGES x PTR_WIDTH flop chain with async active-low reset.
//   - Reused for the write-domain copy of gray_rptr.
// TESTING
//  - Reset with rrst_n low for 64ns, gray_wptr=0, r_en=1 -> empty=1, almost_empty=1, rd_count=0, pointers 0000, underflow=0.
//  - gray_wptr stepped to 0010 (3 writes), r_en=0 -> empty falls and rd_count=3 exactly 3 rclk edges later.
//  - From rd_count=3, r_en held 4 cycles -> binary_rptr 0001,0010,0011 then holds; gray 0001,0011,0010.
//    Empty rises on the 3rd read edge; the 4th edge sets underflow=1.
//    A clr_underflow pulse clears underflow unless r_en&empty occurs on the same edge.
//  - gray_wptr=1100 (8 writes, full), then 8 reads -> rd_count=8 before the reads, 0 after; binary_rptr=1000, gray_rptr=1100.
//    Continue 8 more writes and reads -> binary_rptr wraps to 0000, gray_rptr=0000, and every gray transition flips one bit.
//  - AE_THRESH=1, rd_count=2 -> one read makes almost_empty=1 on that edge while empty stays 0.
//  - rrst_n pulsed low mid-burst -> all outputs return to reset values asynchronously, with no glitch on release.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: default pointer width and gray/binary conversion.
// Both pointer handlers use these, so the two clock domains agree on the encoding.
package fifo_pkg;
    localparam int DEF_PTR_WIDTH = 4;
    localparam int MAX_PTR_W     = 16;

    typedef logic [MAX_PTR_W-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Narrower pointers are zero-extended by the caller; leading zeros convert to zeros.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction
endpackage

// File: rtl/rd_ptr_handler_if.sv
// Read-side FIFO pointer bus: read requests and wptr in, pointers and status flags out.
interface rd_ptr_handler_if #(parameter int PTR_WIDTH = 4);
    logic                 r_en;
    logic                 clr_underflow;
    logic [PTR_WIDTH-1:0] gray_wptr;
    logic [PTR_WIDTH-1:0] binary_rptr;
    logic [PTR_WIDTH-1:0] gray_rptr;
    logic                 empty;
    logic                 almost_empty;
    logic [PTR_WIDTH-1:0] rd_count;
    logic                 underflow;

    modport master (
        output r_en, clr_underflow, gray_wptr,
        input  binary_rptr, gray_rptr, empty, almost_empty, rd_count, underflow
    );

    modport slave (
        input  r_en, clr_underflow, gray_wptr,
        output binary_rptr, gray_rptr, empty, almost_empty, rd_count, underflow
    );
endinterface

// File: rtl/ptr_sync.sv
// Multi-flop synchroniser for a gray-coded pointer crossing clock domains.
// Async active-low reset clears every stage so no stale pointer survives reset.
module ptr_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/rd_ptr_handler.sv
// Read-domain pointer logic of the async FIFO: synchronises the write pointer,
// advances the read pointer and produces empty / almost_empty / count / underflow.
module rd_ptr_handler
    import fifo_pkg::*;
#(
    parameter int PTR_WIDTH   = fifo_pkg::DEF_PTR_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int AE_THRESH   = 1
) (
    input  logic             rclk,
    input  logic             rrst_n,
    rd_ptr_handler_if.slave  bus
);
    logic [PTR_WIDTH-1:0] wptr_s, wptr_bin;
    logic [PTR_WIDTH-1:0] rptr_next, gray_d, count_d;
    logic                 rd_ok, empty_d, ae_d, underflow_d;

    logic [PTR_WIDTH-1:0] bin_q, gray_q, count_q;
    logic                 empty_q, ae_q, underflow_q;

    ptr_sync #(
        .WIDTH  (PTR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk_i  (rclk),
        .rst_ni (rrst_n),
        .d_i    (bus.gray_wptr),
        .q_o    (wptr_s)
    );

    assign wptr_bin  = PTR_WIDTH'(gray2bin(MAX_PTR_W'(wptr_s)));
    assign rd_ok     = bus.r_en & ~empty_q;
    assign rptr_next = bin_q + PTR_WIDTH'(rd_ok);
    assign gray_d    = PTR_WIDTH'(bin2gray(MAX_PTR_W'(rptr_next)));

    // Flags are computed from the post-read pointer so empty rises on the edge
    // that consumes the last word, and count/almost_empty never disagree.
    assign count_d     = wptr_bin - rptr_next;
    assign empty_d     = (gray_d == wptr_s);
    assign ae_d        = (count_d <= PTR_WIDTH'(AE_THRESH));
    assign underflow_d = (bus.r_en & empty_q) | (underflow_q & ~bus.clr_underflow);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            bin_q       <= '0;
            gray_q      <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            ae_q        <= 1'b1;
            underflow_q <= 1'b0;
        end else begin
            bin_q       <= rptr_next;
            gray_q      <= gray_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            ae_q        <= ae_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.binary_rptr  = bin_q;
    assign bus.gray_rptr    = gray_q;
    assign bus.rd_count     = count_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = ae_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_rd_ptr_handler.sv
// Directed bench for rd_ptr_handler: vector table for sync latency, reads, underflow
// and almost_empty, plus hand sequences for mid-burst reset and full-depth wrap.
module tb_rd_ptr_handler;
    import fifo_pkg::*;

    localparam int W = 4;

    logic rclk = 1'b0;
    logic rrst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    rd_ptr_handler_if #(.PTR_WIDTH(W)) bus ();

    rd_ptr_handler #(
        .PTR_WIDTH   (W),
        .SYNC_STAGES (2),
        .AE_THRESH   (1)
    ) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus.slave)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic         r_en;
        logic         clr;
        logic [W-1:0] gw;
        logic [W-1:0] e_bin;
        logic [W-1:0] e_gray;
        logic         e_empty;
        logic         e_ae;
        logic [W-1:0] e_cnt;
        logic         e_uf;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] b, input logic [W-1:0] g,
                           input logic e, input logic ae, input logic [W-1:0] c, input logic uf);
        chk({tag, ".bin"},   32'(bus.binary_rptr),  32'(b));
        chk({tag, ".gray"},  32'(bus.gray_rptr),    32'(g));
        chk({tag, ".empty"}, 32'(bus.empty),        32'(e));
        chk({tag, ".ae"},    32'(bus.almost_empty), 32'(ae));
        chk({tag, ".cnt"},   32'(bus.rd_count),     32'(c));
        chk({tag, ".uf"},    32'(bus.underflow),    32'(uf));
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    initial begin
        logic [W-1:0] prev_g, eb;

        //          r_en clr  gw       bin      gray     e     ae    cnt      uf
        vecs[0]  = '{1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'd3, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'b0010, 4'b0001, 4'b0001, 1'b0, 1'b0, 4'd2, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 4'b0010, 4'b0010, 4'b0011, 1'b0, 1'b1, 4'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'b0010, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'b0010, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'b0010, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'b0010, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 4'b0010, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'b0010, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 4'b0010, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0};
        // write pointer to 5 (gray 0111): count 2, then reads through almost_empty to empty
        vecs[12] = '{1'b0, 1'b0, 4'b0111, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'b0111, 4'b0011, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'b0111, 4'b0011, 4'b0010, 1'b0, 1'b0, 4'd2, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 4'b0111, 4'b0100, 4'b0110, 1'b0, 1'b1, 4'd1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 4'b0111, 4'b0101, 4'b0111, 1'b1, 1'b1, 4'd0, 1'b0};

        bus.r_en = 1'b1;
        bus.clr_underflow = 1'b0;
        bus.gray_wptr = '0;
        #64;
        chk_all("reset", 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        @(negedge rclk);
        bus.r_en = 1'b0;
        rrst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            bus.r_en = vecs[i].r_en;
            bus.clr_underflow = vecs[i].clr;
            bus.gray_wptr = vecs[i].gw;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].e_bin, vecs[i].e_gray, vecs[i].e_empty,
                    vecs[i].e_ae, vecs[i].e_cnt, vecs[i].e_uf);
        end
        bus.r_en = 1'b0;
        bus.clr_underflow = 1'b0;

        // mid-burst reset: wptr 7, read in flight, reset asserted between edges
        bus.gray_wptr = 4'b0100;
        repeat (3) step();
        chk("mb.cnt_pre", 32'(bus.rd_count), 32'd2);
        bus.r_en = 1'b1;
        step();
        chk("mb.bin_pre", 32'(bus.binary_rptr), 32'd6);
        #2 rrst_n = 1'b0;
        #1;
        chk_all("async_rst", 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0);
        bus.r_en = 1'b0;
        bus.gray_wptr = '0;
        repeat (2) step();
        @(negedge rclk);
        rrst_n = 1'b1;
        step();
        chk_all("rst_release", 4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0);

        // full depth then wrap: two rounds of 8 writes and 8 reads
        for (int round = 0; round < 2; round++) begin
            bus.r_en = 1'b0;
            bus.gray_wptr = (round == 0) ? 4'b1100 : 4'b0000;
            repeat (3) step();
            chk($sformatf("full%0d.cnt", round), 32'(bus.rd_count), 32'd8);
            chk($sformatf("full%0d.empty", round), 32'(bus.empty), 32'd0);
            chk($sformatf("full%0d.ae", round), 32'(bus.almost_empty), 32'd0);
            prev_g = bus.gray_rptr;
            bus.r_en = 1'b1;
            for (int k = 0; k < 8; k++) begin
                step();
                eb = W'(round * 8 + k + 1);
                chk($sformatf("r%0d_%0d.bin", round, k), 32'(bus.binary_rptr), 32'(eb));
                chk($sformatf("r%0d_%0d.onebit", round, k),
                    32'($countones(bus.gray_rptr ^ prev_g)), 32'd1);
                chk($sformatf("r%0d_%0d.cnt", round, k), 32'(bus.rd_count), 32'(7 - k));
                prev_g = bus.gray_rptr;
            end
            bus.r_en = 1'b0;
            chk($sformatf("done%0d.gray", round), 32'(bus.gray_rptr),
                (round == 0) ? 32'b1100 : 32'b0000);
            chk($sformatf("done%0d.empty", round), 32'(bus.empty), 32'd1);
            chk($sformatf("done%0d.uf", round), 32'(bus.underflow), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
